// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter driving the open-drain clock/data pins.
// Define PS2_TX_RESEND_EN to retry a NACKed or timed-out byte up to three times before txError.
module ps2_host_transmitter #(
   parameter int ClkFrequency = 100_000_000,
   parameter int InhibitUs    = 100,
   parameter int TimeoutUs    = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       txStart,
   input  logic [7:0] txData,
   input  logic       ps2ClkIn,
   input  logic       ps2DataIn,
   output logic       ps2ClkOe,
   output logic       ps2DataOe,
   output logic       txBusy,
   output logic       txDone,
   output logic       txError,
   output logic       txActive
);

   localparam int InhibitCycles = ClkFrequency / 1000000 * InhibitUs;
   localparam int TimeoutCycles = ClkFrequency / 1000000 * TimeoutUs;
   localparam int TimerMax      = (InhibitCycles > TimeoutCycles) ? InhibitCycles : TimeoutCycles;
   localparam int TimerW        = $clog2(TimerMax + 1);
   localparam logic [TimerW-1:0] InhibitLast = TimerW'(InhibitCycles - 1);
   localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TimeoutCycles - 1);
   localparam logic [TimerW-1:0] TimerSat    = TimerW'(TimerMax);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

   state_t            state, state_next;
   logic [1:0]        clk_sync, data_sync;
   logic              clk_prev;
   logic              clk_s, data_s, fe;
   logic [7:0]        data_reg, data_next;
   logic              parity_reg, parity_next;
   logic [3:0]        bit_cnt, bit_cnt_next;
   logic [TimerW-1:0] timer, timer_next;
   logic              drive_data, drive_data_next;
   logic              done_next, error_next;
   logic              fail;
`ifdef PS2_TX_RESEND_EN
   logic [1:0]        retry_cnt, retry_next;
`endif

   // Synchronizers idle high so a reset never fabricates a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2ClkIn};
         data_sync <= {data_sync[0], ps2DataIn};
         clk_prev  <= clk_sync[1];
      end
   end

   assign clk_s = clk_sync[1];
   assign data_s = data_sync[1];
   assign fe = clk_prev & ~clk_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         data_reg   <= '0;
         parity_reg <= 1'b0;
         bit_cnt    <= '0;
         timer      <= '0;
         drive_data <= 1'b0;
         txDone     <= 1'b0;
         txError    <= 1'b0;
`ifdef PS2_TX_RESEND_EN
         retry_cnt  <= '0;
`endif
      end else begin
         state      <= state_next;
         data_reg   <= data_next;
         parity_reg <= parity_next;
         bit_cnt    <= bit_cnt_next;
         timer      <= timer_next;
         drive_data <= drive_data_next;
         txDone     <= done_next;
         txError    <= error_next;
`ifdef PS2_TX_RESEND_EN
         retry_cnt  <= retry_next;
`endif
      end
   end

   // The REQ-state falling edge already shifts out data bit 0, so in SEND
   // bit_cnt is the index of the bit driven on the current edge.
   always_comb begin
      state_next      = state;
      data_next       = data_reg;
      parity_next     = parity_reg;
      bit_cnt_next    = bit_cnt;
      timer_next      = (timer == TimerSat) ? timer : timer + 1'b1;
      drive_data_next = drive_data;
      done_next       = 1'b0;
      error_next      = 1'b0;
      fail            = 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_next      = retry_cnt;
`endif
      case (state)
         IDLE: begin
            timer_next      = '0;
            drive_data_next = 1'b0;
            if (txStart) begin
               data_next   = txData;
               parity_next = ~^txData;
               state_next  = INHIBIT;
`ifdef PS2_TX_RESEND_EN
               retry_next  = '0;
`endif
            end
         end
         INHIBIT: begin
            if (timer == InhibitLast) begin
               state_next      = REQ;
               timer_next      = '0;
               bit_cnt_next    = '0;
               drive_data_next = 1'b1;
            end
         end
         REQ: begin
            if (fe) begin
               drive_data_next = ~data_reg[0];
               bit_cnt_next    = 4'd1;
               timer_next      = '0;
               state_next      = SEND;
            end else if (timer == TimeoutLast) begin
               fail = 1'b1;
            end
         end
         SEND: begin
            if (fe) begin
               timer_next   = '0;
               bit_cnt_next = bit_cnt + 4'd1;
               if (bit_cnt < 4'd8) begin
                  drive_data_next = ~data_reg[bit_cnt[2:0]];
               end else if (bit_cnt == 4'd8) begin
                  drive_data_next = ~parity_reg;
               end else begin
                  drive_data_next = 1'b0;
                  state_next      = ACK;
               end
            end else if (timer == TimeoutLast) begin
               fail = 1'b1;
            end
         end
         ACK: begin
            if (fe) begin
               timer_next = '0;
               if (!data_s) state_next = WAIT_IDLE;
               else fail = 1'b1;
            end else if (timer == TimeoutLast) begin
               fail = 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (clk_s && data_s) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end else if (fe) begin
               timer_next = '0;
            end else if (timer == TimeoutLast) begin
               fail = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      if (fail) begin
         drive_data_next = 1'b0;
`ifdef PS2_TX_RESEND_EN
         if (retry_cnt == 2'd3) begin
            state_next = IDLE;
            error_next = 1'b1;
         end else begin
            retry_next = retry_cnt + 2'd1;
            state_next = INHIBIT;
            timer_next = '0;
         end
`else
         state_next = IDLE;
         error_next = 1'b1;
`endif
      end
   end

   assign ps2ClkOe  = (state == INHIBIT);
   assign ps2DataOe = drive_data | ((state == INHIBIT) && (timer == InhibitLast));
   assign txBusy    = (state != IDLE);
   assign txActive  = (state != IDLE);

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
- Host-to-device PS/2 transmitter; sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
- Complements the existing PS/2 receive path on the same open-drain clock/data pins.
- Sits beside the keyboard receiver in the console top level and is driven by console control logic.
- Asserts txActive so the receiver ignores traffic that the host itself generates.

Parameters:
- ClkFrequency, 100000000, system clock frequency in Hz.
- InhibitUs, 100, time clock is held low before request-to-send, in µs. InhibitCycles = ClkFrequency/1000000*InhibitUs.
- TimeoutUs, 2000, maximum gap between device clock falling edges before abort, in µs. TimeoutCycles is derived the same way.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- txStart  in  1  1-cycle request to send txData; accepted only when txBusy=0
- txData  in  8  byte to send, captured on an accepted txStart
- ps2ClkIn  in  1  raw PS/2 clock pin level
- ps2DataIn  in  1  raw PS/2 data pin level
- ps2ClkOe  out  1  1 = drive clock pin low; 0 = release
- ps2DataOe  out  1  1 = drive data pin low; 0 = release
- txBusy  out  1  high from accepted start until done/error
- txDone  out  1  1-cycle pulse when the device ACKs
- txError  out  1  1-cycle pulse on NACK or timeout
- txActive  out  1  high while in any non-IDLE state; receiver gating

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Both lines are released the cycle after rst is sampled, including when rst arrives mid-transfer.
- Pin inputs: 2-FF synchronizers. Falling edge (fe) = previous synchronized clock 1, current 0.
- Capture: on accepted txStart, latch txData and oddParity = ~^txData, then enter INHIBIT. txStart while busy is ignored. If rst and txStart occur together, reset wins.
- INHIBIT:
  - ps2ClkOe=1 for InhibitCycles.
  - ps2DataOe=1 during the final cycle (start bit 0).
  - Then go to REQ.
- REQ:
  - ps2ClkOe=0, ps2DataOe=1; bitCnt=0; timer cleared.
  - Wait for the first fe, then go to SEND.
- SEND: on each fe, drive the next bit with ps2DataOe = ~bit.
  - bitCnt 0–7: data bits, LSB first.
  - bitCnt 8: parity.
  - bitCnt 9: stop bit (release, ps2DataOe=0).
  - bitCnt increments per fe. After the stop-bit fe, go to ACK.
- ACK:
  - On the next fe, sample synchronized data. 0 = ACK, 1 = NACK.
  - ACK: go to WAIT_IDLE.
  - NACK: txError pulse, go to IDLE.
- WAIT_IDLE: wait until synchronized clock=1 and data=1, then txDone pulse and go to IDLE.
- Timing of flags: txBusy and txActive drop in the same cycle as the txDone/txError pulse. txDone and txError are never asserted together.
- Timeout: in REQ, SEND, ACK and WAIT_IDLE, the timer counts cycles since the last fe (or since state entry). Reaching TimeoutCycles causes:
  - release of both lines,
  - a txError pulse,
  - a return to IDLE.
- Line updates: data changes only in the cycle after a detected fe, so it is stable well before the device's rising-edge sample.
- Counters: the timer is wide enough for max(InhibitCycles, TimeoutCycles). The timer saturates and does not wrap.

Optional Feature:
- Macro: PS2_TX_RESEND_EN.
- Defined:
  - On NACK or timeout, the block re-enters INHIBIT with the latched byte.
  - Up to 3 retries, counted by a 2-bit retry counter cleared on accept.
  - txError pulses only after the 3rd retry fails; txBusy stays high throughout.
  - Success on any attempt gives txDone.
- Undefined: first NACK or timeout gives txError immediately; no retry counter exists.

Test Plan:
- Reset mid-SEND: ps2ClkOe, ps2DataOe, txBusy and txActive are all 0 one cycle after rst. A fresh txStart afterwards is accepted normally.
- Send 0xED (ClkFrequency=1000000, InhibitUs=100): ps2ClkOe high exactly 100 cycles. Device model then clocks at ~12.5 kHz; released-data bits sampled are 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ACKs low, txDone pulses once, txBusy falls.
- Send 0x01: parity bit 0 observed on the line; txDone asserted.
- Device NACKs (data high at the 11th fe) with macro off: txError pulses once, no txDone, lines released.
- Device stops clocking after 4 bits: txError exactly TimeoutCycles after the last fe, both Oe=0. txStart during busy is ignored, with txData unchanged on the line.
- With PS2_TX_RESEND_EN: device NACKs twice then ACKs gives 3 INHIBIT phases and a single txDone. Four consecutive NACKs give a single txError.
